// File: rtl/result_serializer_pkg.sv
// Shared bus-width defines plus the serializer's constants and FSM encoding.
// Widths here must track the keyed input buffer so both ends agree on chunk size.
`ifndef RESULT_SERIALIZER_DEFINES
`define RESULT_SERIALIZER_DEFINES
`define DATABUS   2
`define RESBUS    4
`define RES_BEATS 8
`define RS_IDLE   1'b0
`define RS_SEND   1'b1
`endif

package result_serializer_pkg;

    localparam int RS_DATA_W  = `DATABUS;
    localparam int RS_RES_W   = `RESBUS;
    localparam int RS_NUM_RES = 4;
    localparam int RS_BEATS   = `RES_BEATS;

    typedef enum logic {
        ST_IDLE = `RS_IDLE,
        ST_SEND = `RS_SEND
    } state_t;

endpackage

// File: rtl/result_serializer.sv
// Captures four result words on start and streams them MS-chunk-first over a valid/ready port.
// One chunk per cycle; tx_ready low stalls with outputs held; done pulses after the last accept.
module result_serializer
    import result_serializer_pkg::*;
#(
    parameter int DATA_W  = RS_DATA_W,
    parameter int RES_W   = RS_RES_W,
    parameter int NUM_RES = RS_NUM_RES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [RES_W-1:0]  res0,
    input  logic [RES_W-1:0]  res1,
    input  logic [RES_W-1:0]  res2,
    input  logic [RES_W-1:0]  res3,
    input  logic              tx_ready,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_last,
    output logic              busy,
    output logic              done
);

    localparam int SR_W  = NUM_RES * RES_W;
    localparam int BEATS = SR_W / DATA_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    if (RES_W % DATA_W != 0) begin : g_bad_ratio
        $error("RES_W must be a multiple of DATA_W");
    end
    if (DATA_W != RS_DATA_W || RES_W != RS_RES_W || NUM_RES != 4 || BEATS != RS_BEATS) begin : g_bad_cfg
        $error("widths must match DATABUS/RESBUS and four result ports");
    end

    state_t            state_q, state_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sr_d    = {res0, res1, res2, res3};
                    cnt_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tx_ready) begin
                    if (cnt_q == LAST_BEAT) begin
                        // Clearing the register keeps tx_data at zero while idle.
                        state_d = ST_IDLE;
                        sr_d    = '0;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        sr_d  = sr_q << DATA_W;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign tx_valid = (state_q == ST_SEND);
    assign busy     = (state_q == ST_SEND);
    assign tx_data  = sr_q[SR_W-1 -: DATA_W];
    assign tx_last  = tx_valid && (cnt_q == LAST_BEAT);
    assign done     = done_q;

endmodule
